// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two requester ports, their responses, and the word-only data memory bus
interface dmem_arbiter_if;
  logic        req0_valid, req0_ready, req0_we;
  logic [2:0]  req0_funct3;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [2:0]  req1_funct3;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  modport slave (
    input  req0_valid, req0_we, req0_funct3, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_funct3, req1_addr, req1_wdata, mem_rdata,
    output req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    output rsp1_valid, rsp1_err, rsp1_rdata,
    output mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
  );
  modport master (
    output req0_valid, req0_we, req0_funct3, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_funct3, req1_addr, req1_wdata, mem_rdata,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_err, rsp0_rdata,
    input  rsp1_valid, rsp1_err, rsp1_rdata,
    input  mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter onto a word-only data memory; DMEM_ARB_RMW_EN enables sb/sh via read-modify-write
module dmem_arbiter (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
`ifdef DMEM_ARB_RMW_EN
  typedef enum logic [2:0] {IDLE, READ, WRITE, RMW_RD, RMW_WR} state_t;
  localparam logic RMW = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam logic RMW = 1'b0;
`endif
  state_t           state_q, state_d;
  logic             ptr_q, ptr_d, port_q, gnt, take, err, rd, wr, done;
  logic [1:0]       valid, rsp_valid_q, rsp_err_q;
  logic [1:0][31:0] rsp_rdata_q;
  logic [2:0]       f3_q, sel_f3;
  logic             sel_we;
  logic [31:0]      addr_q, wdata_q, sel_addr, sel_wdata;
`ifdef DMEM_ARB_RMW_EN
  logic [31:0]      word_q, mask, merged;
  assign mask   = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {addr_q[1:0], 3'b000};
  assign merged = (word_q & ~mask) | ((wdata_q << {addr_q[1:0], 3'b000}) & mask);
  assign rd     = state_q == READ || state_q == RMW_RD;
  assign wr     = state_q == WRITE || state_q == RMW_WR;
`else
  assign rd     = state_q == READ;
  assign wr     = state_q == WRITE;
`endif
  assign valid     = {bus.req1_valid, bus.req0_valid};
  assign gnt       = &valid ? ptr_q : valid[1];
  assign take      = state_q == IDLE && |valid && !rst;
  assign bus.req0_ready = take && !gnt;
  assign bus.req1_ready = take && gnt;
  assign sel_we    = gnt ? bus.req1_we : bus.req0_we;
  assign sel_f3    = gnt ? bus.req1_funct3 : bus.req0_funct3;
  assign sel_addr  = gnt ? bus.req1_addr : bus.req0_addr;
  assign sel_wdata = gnt ? bus.req1_wdata : bus.req0_wdata;
  assign err = sel_f3 == 3'b011 || sel_f3[2:1] == 2'b11 || (sel_we && sel_f3[2]) ||
               (sel_f3 == 3'b010 && sel_addr[1:0] != 2'b00) || (sel_f3[1:0] == 2'b01 && sel_addr[0]) ||
               (!RMW && sel_we && sel_f3 != 3'b010);
  assign done = state_q == READ || wr;
  assign bus.mem_read   = rd;
  assign bus.mem_write  = wr;
  assign bus.mem_funct3 = 3'b010;
  assign bus.mem_addr   = rd || wr ? {addr_q[31:2], 2'b00} : 32'h0;
`ifdef DMEM_ARB_RMW_EN
  assign bus.mem_wdata  = state_q == WRITE ? wdata_q : state_q == RMW_WR ? merged : 32'h0;
`else
  assign bus.mem_wdata  = state_q == WRITE ? wdata_q : 32'h0;
`endif
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_err   = rsp_err_q[0];
  assign bus.rsp1_err   = rsp_err_q[1];
  assign bus.rsp0_rdata = rsp_rdata_q[0];
  assign bus.rsp1_rdata = rsp_rdata_q[1];

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = a[1] ? (a[0] ? w[31:24] : w[23:16]) : (a[0] ? w[15:8] : w[7:0]);
    h = a[1] ? w[31:16] : w[15:0];
    return f3[1:0] == 2'b00 ? {{24{b[7] & !f3[2]}}, b} : f3[1:0] == 2'b01 ? {{16{h[15] & !f3[2]}}, h} : w;
  endfunction

  // next state: accepts leave IDLE unless rejected; every access state returns to IDLE except RMW_RD
  always_comb begin
    ptr_d   = take && &valid ? ~ptr_q : ptr_q;
    state_d = IDLE;
`ifdef DMEM_ARB_RMW_EN
    if (take && !err) state_d = !sel_we ? READ : sel_f3 == 3'b010 ? WRITE : RMW_RD;
    if (state_q == RMW_RD) state_d = RMW_WR;
`else
    if (take && !err) state_d = sel_we ? WRITE : READ;
`endif
  end

  // state, captured request, and one-cycle responses routed to the granted port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      port_q      <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
`ifdef DMEM_ARB_RMW_EN
      word_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
      if (take) begin
        port_q  <= gnt;
        f3_q    <= sel_f3;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (take && err) begin
        rsp_valid_q[gnt] <= 1'b1;
        rsp_err_q[gnt]   <= 1'b1;
      end
      if (done) rsp_valid_q[port_q] <= 1'b1;
      if (state_q == READ) rsp_rdata_q[port_q] <= load_ext(f3_q, addr_q[1:0], bus.mem_rdata);
`ifdef DMEM_ARB_RMW_EN
      if (state_q == RMW_RD) word_q <= bus.mem_rdata;
`endif
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors plus round-robin and mid-transaction reset sequences
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();
  dmem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
  always @(posedge clk)
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (bus.mem_write) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;

  int n_rd = 0, n_wr = 0, n_rsp = 0, n_both = 0;
  always @(negedge clk) begin
    if (bus.mem_read) n_rd++;
    if (bus.mem_write) n_wr++;
    if (bus.rsp0_valid || bus.rsp1_valid) n_rsp++;
    if (bus.req0_ready && bus.req1_ready) n_both++;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(input int port, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat, input logic err, input logic [31:0] rdata);
    vec_t v;
    v.port = port; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  task automatic drive(input int p, input logic v, input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_funct3 = f3; bus.req0_addr = addr; bus.req0_wdata = wdata;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_funct3 = f3; bus.req1_addr = addr; bus.req1_wdata = wdata;
    end
  endtask

  function automatic logic rv(input int p);
    return p == 0 ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  task automatic do_req(input vec_t v, input string nm);
    int lat, r0, w0;
    logic e, oth;
    logic [31:0] rd;
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.f3, v.addr, v.wdata);
    #1;
    chk({nm, "_ready"}, v.port == 0 ? bus.req0_ready : bus.req1_ready, 32'd1);
    r0 = n_rd; w0 = n_wr;
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    lat = 0; e = 1'b0; oth = 1'b0; rd = '0;
    for (int k = 1; k <= 6; k++) begin
      if (rv(v.port)) begin
        lat = k;
        e   = v.port == 0 ? bus.rsp0_err : bus.rsp1_err;
        rd  = v.port == 0 ? bus.rsp0_rdata : bus.rsp1_rdata;
        oth = rv(1 - v.port);
        break;
      end
      @(posedge clk); #1;
    end
    chk({nm, "_latency"}, lat, v.lat);
    chk({nm, "_err"}, e, v.err);
    chk({nm, "_rdata"}, rd, v.rdata);
    chk({nm, "_other_port_quiet"}, oth, 32'd0);
    @(posedge clk); #1;
    chk({nm, "_pulse_one_cycle"}, rv(v.port), 32'd0);
    if (v.err) begin
      chk({nm, "_no_mem_read"}, n_rd - r0, 32'd0);
      chk({nm, "_no_mem_write"}, n_wr - w0, 32'd0);
    end
  endtask

  vec_t tv[$];
  int g[4], cy[4], n, w0, r0;
  logic rmw;

  initial begin
`ifdef DMEM_ARB_RMW_EN
    rmw = 1'b1;
`else
    rmw = 1'b0;
`endif
    drive(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_idx = 4'(i);
      pre_val = i == 0 ? 32'h7 : i == 4 ? 32'h80FF1234 : i == 5 ? 32'h11111111 : 32'h0;
    end
    @(negedge clk); pre_we = 1'b0; #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_rsp_err", {bus.rsp0_err, bus.rsp1_err}, 0);
    chk("rst_rdata", bus.rsp0_rdata | bus.rsp1_rdata, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);

    // round-robin from reset with both ports continuously valid
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (bus.req0_ready) begin g[n] = 0; cy[n] = c; n++; end
      else if (bus.req1_ready) begin g[n] = 1; cy[n] = c; n++; end
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("rr_grant_count", n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), g[i], i % 2);
    for (int i = 1; i < 4; i++) chk($sformatf("rr_back_to_back%0d", i), cy[i] - cy[i-1], 2);
    repeat (3) @(posedge clk);

    tv.push_back(mk(0, 0, 3'b010, 32'h00, 0, 2, 0, 32'h00000007));
    tv.push_back(mk(1, 0, 3'b000, 32'h11, 0, 2, 0, 32'h00000012));
    tv.push_back(mk(0, 0, 3'b100, 32'h13, 0, 2, 0, 32'h00000080));
    tv.push_back(mk(1, 0, 3'b001, 32'h12, 0, 2, 0, 32'hFFFF80FF));
    tv.push_back(mk(0, 0, 3'b101, 32'h12, 0, 2, 0, 32'h000080FF));
    tv.push_back(mk(0, 0, 3'b010, 32'h10, 0, 2, 0, 32'h80FF1234));
    tv.push_back(mk(1, 0, 3'b010, 32'h06, 0, 1, 1, 32'h0));
    tv.push_back(mk(0, 0, 3'b001, 32'h11, 0, 1, 1, 32'h0));
    tv.push_back(mk(0, 0, 3'b011, 32'h00, 0, 1, 1, 32'h0));
    tv.push_back(mk(1, 1, 3'b100, 32'h00, 32'h5, 1, 1, 32'h0));
    tv.push_back(mk(0, 1, 3'b010, 32'h09, 32'h5, 1, 1, 32'h0));
    tv.push_back(mk(0, 1, 3'b010, 32'h08, 32'hDEADBEEF, 2, 0, 32'h0));
    tv.push_back(mk(1, 0, 3'b010, 32'h08, 0, 2, 0, 32'hDEADBEEF));
    tv.push_back(mk(0, 0, 3'b000, 32'h0B, 0, 2, 0, 32'hFFFFFFDE));
    tv.push_back(mk(1, 0, 3'b010, 32'h00, 0, 2, 0, 32'h00000007));
    tv.push_back(mk(0, 1, 3'b000, 32'h11, 32'hFFFFFFAB, rmw ? 3 : 1, !rmw, 32'h0));
    tv.push_back(mk(1, 0, 3'b010, 32'h10, 0, 2, 0, rmw ? 32'h80FFAB34 : 32'h80FF1234));
    tv.push_back(mk(1, 1, 3'b001, 32'h12, 32'h12345566, rmw ? 3 : 1, !rmw, 32'h0));
    tv.push_back(mk(0, 0, 3'b010, 32'h10, 0, 2, 0, rmw ? 32'h5566AB34 : 32'h80FF1234));
    tv.push_back(mk(0, 1, 3'b001, 32'h13, 32'h1, 1, 1, 32'h0));
    foreach (tv[i]) do_req(tv[i], $sformatf("v%0d", i));

    // reset while a store is in flight: no write, no response, ready after release
    @(negedge clk);
    drive(0, 1'b1, 1'b1, rmw ? 3'b001 : 3'b010, rmw ? 32'h16 : 32'h14, rmw ? 32'h9999 : 32'hCAFEF00D);
    @(posedge clk); #1;
    rst = 1'b1;
    w0 = n_wr; r0 = n_rsp;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("midrst_ready%0d", k), bus.req0_ready, 0);
      chk($sformatf("midrst_mem_write%0d", k), bus.mem_write, 0);
    end
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("midrst_no_write", n_wr - w0, 0);
    chk("midrst_no_rsp", n_rsp - r0, 0);
    do_req(mk(0, 0, 3'b010, 32'h14, 0, 2, 0, 32'h11111111), "midrst_after");
    chk("never_both_ready", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
